// File: rtl/mem_bus_arbiter.sv
// Arbitrates one Wishbone-classic bus between instruction fetch and the MEM stage (MEM first).
// Optional access timeout is compiled in with `define ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TMO_W          = 8
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_ce_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_data_o,
    output logic                if_stallreq_o,

    input  logic                mem_ce_i,
    input  logic                mem_we_i,
    input  logic [DATA_W/8-1:0] mem_sel_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_data_i,
    output logic [DATA_W-1:0]   mem_data_o,
    output logic                mem_stallreq_o,

    output logic                bus_cyc_o,
    output logic                bus_stb_o,
    output logic                bus_we_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_data_o,
    input  logic [DATA_W-1:0]   bus_data_i,
    input  logic                bus_ack_i,
    output logic                bus_timeout_o
);

    localparam int unsigned SelW = DATA_W / 8;

    if (TIMEOUT_CYCLES == 0 || 64'(TIMEOUT_CYCLES) >= (64'd1 << TMO_W)) begin : g_tmo_cfg_err
        $error("TMO_W too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
    typedef enum logic {OwnIf, OwnMem} owner_e;

    state_e              state_q;
    owner_e              owner_q;
    logic                withdrawn_q;
    logic                bus_cyc_q;
    logic                bus_we_q;
    logic [SelW-1:0]     bus_sel_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [DATA_W-1:0]   bus_data_q;
    logic [DATA_W-1:0]   if_data_q;
    logic [DATA_W-1:0]   mem_data_q;
    logic                timeout_q;

`ifdef ARB_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0]    tmo_q;
`endif

    logic owner_ce;
    logic keep;

    // A dropped ce at any point of BUSY (flush) discards the result.
    assign owner_ce = (owner_q == OwnMem) ? mem_ce_i : if_ce_i;
    assign keep     = owner_ce & ~withdrawn_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= OwnIf;
            withdrawn_q <= 1'b0;
            bus_cyc_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_data_q  <= '0;
            if_data_q   <= '0;
            mem_data_q  <= '0;
            timeout_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (mem_ce_i) begin
                        owner_q     <= OwnMem;
                        bus_addr_q  <= mem_addr_i;
                        bus_we_q    <= mem_we_i;
                        bus_sel_q   <= mem_sel_i;
                        bus_data_q  <= mem_data_i;
                        bus_cyc_q   <= 1'b1;
                        withdrawn_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                        tmo_q       <= '0;
`endif
                        state_q     <= StBusy;
                    end else if (if_ce_i) begin
                        owner_q     <= OwnIf;
                        bus_addr_q  <= if_addr_i;
                        bus_we_q    <= 1'b0;
                        bus_sel_q   <= '1;
                        bus_data_q  <= '0;
                        bus_cyc_q   <= 1'b1;
                        withdrawn_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                        tmo_q       <= '0;
`endif
                        state_q     <= StBusy;
                    end
                end
                StBusy: begin
                    if (!owner_ce) begin
                        withdrawn_q <= 1'b1;
                    end
                    if (bus_ack_i) begin
                        bus_cyc_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        if (keep) begin
                            if (!bus_we_q) begin
                                if (owner_q == OwnMem) mem_data_q <= bus_data_i;
                                else                   if_data_q  <= bus_data_i;
                            end
                            state_q <= StDone;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tmo_q == TmoLast) begin
                        bus_cyc_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        timeout_q <= 1'b1;
                        if (keep) begin
                            if (!bus_we_q) begin
                                if (owner_q == OwnMem) mem_data_q <= '1;
                                else                   if_data_q  <= '1;
                            end
                            state_q <= StDone;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign if_stallreq_o  = if_ce_i  & ~(state_q == StDone && owner_q == OwnIf);
    assign mem_stallreq_o = mem_ce_i & ~(state_q == StDone && owner_q == OwnMem);

    assign if_data_o     = if_data_q;
    assign mem_data_o    = mem_data_q;
    assign bus_cyc_o     = bus_cyc_q;
    assign bus_stb_o     = bus_cyc_q;
    assign bus_we_o      = bus_we_q;
    assign bus_sel_o     = bus_sel_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_data_o    = bus_data_q;
    assign bus_timeout_o = timeout_q;

endmodule
